jc_ctrl: RTL

Control front-end for the 4-bit Johnson counter stage. Turns three raw, bouncy push-buttons into a registered direction level (`LEFT`) and a one-cycle clock-enable strobe (`CE`) at a programmable rate. It sits directly upstream of the Johnson counter, and its `LEFT`/`CE` outputs wire straight to the counter's `LEFT`/`CE` inputs on the same `CLK`.

---
 rtl/jc_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/jc_ctrl.sv
// Johnson-counter control front-end: synchronizes and debounces the buttons, runs a
// STOP/RUN_L/RUN_R FSM and generates the LEFT level and the CE strobe.
// Optional single-step button is enabled by defining JC_CTRL_STEP_EN.
module jc_ctrl #(
  parameter int DIV       = 50000,
  parameter int DB_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_LEFT,
  input  logic BTN_RIGHT,
  input  logic BTN_STOP,
`ifdef JC_CTRL_STEP_EN
  input  logic BTN_STEP,
`endif
  output logic CE,
  output logic LEFT,
  output logic RUNNING
);

  // Button slots: 0 = stop, 1 = left, 2 = right, 3 = step (optional)
`ifdef JC_CTRL_STEP_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam int PW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN_L = 2'd1,
    ST_RUN_R = 2'd2
  } state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] stable_q;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] ev_q;
  logic [CW-1:0] cnt_q [NB];

  state_t        state_q;
  logic          ce_q;
  logic          left_q;
  logic          running_q;
  logic [PW-1:0] presc_q;

`ifdef JC_CTRL_STEP_EN
  assign btn_raw = {BTN_STEP, BTN_RIGHT, BTN_LEFT, BTN_STOP};
`else
  assign btn_raw = {BTN_RIGHT, BTN_LEFT, BTN_STOP};
`endif

  // Synchronizer, debounce and press-event pulse; the counter only runs while the
  // synchronized level disagrees with the accepted one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      ev_q     <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= stable_q;
      ev_q    <= stable_q & ~prev_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // FSM with registered outputs; the if-chain order gives STOP > LEFT > RIGHT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_STOP;
      ce_q      <= 1'b0;
      left_q    <= 1'b0;
      running_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      ce_q <= 1'b0;
      if (ev_q[0]) begin
        state_q   <= ST_STOP;
        running_q <= 1'b0;
        presc_q   <= '0;
      end else if (ev_q[1]) begin
        state_q   <= ST_RUN_L;
        left_q    <= 1'b1;
        running_q <= 1'b1;
        presc_q   <= '0;
      end else if (ev_q[2]) begin
        state_q   <= ST_RUN_R;
        left_q    <= 1'b0;
        running_q <= 1'b1;
        presc_q   <= '0;
      end else if (state_q == ST_STOP) begin
        presc_q <= '0;
`ifdef JC_CTRL_STEP_EN
        ce_q    <= ev_q[3];
`endif
      end else if (presc_q == PS_LAST) begin
        presc_q <= '0;
        ce_q    <= 1'b1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign CE      = ce_q;
  assign LEFT    = left_q;
  assign RUNNING = running_q;

endmodule
